symbol_export_resolver: RTL and testbench



---
 rtl/symbol_export_resolver.sv | 219 +++++++++++++++++++++
 tb/tb_symbol_export_resolver.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/symbol_export_resolver.sv
// Export/import resolver: per-namespace table of LOCAL and PROMOTED symbols, one op at a time.
// Optional SYMRES_STATS_EN adds a saturating conflict counter output (conflict_cnt).
module symbol_export_resolver #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SYM_W = 8,
    parameter int unsigned PKG_W = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_op,
    input  logic                         in_ns,
    input  logic [SYM_W-1:0]             in_sym,
    input  logic [PKG_W-1:0]             in_pkg,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [2:0]                   rsp_status,
    output logic                         rsp_local,
    output logic [PKG_W-1:0]             rsp_pkg,
`ifdef SYMRES_STATS_EN
    output logic [15:0]                  conflict_cnt,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    localparam logic [1:0] OP_DECL   = 2'd0;
    localparam logic [1:0] OP_EXPORT = 2'd1;
    localparam logic [1:0] OP_LOOKUP = 2'd2;
    localparam logic [1:0] OP_CLEAR  = 2'd3;

    localparam logic [2:0] ST_OK       = 3'd0;
    localparam logic [2:0] ST_CONFLICT = 3'd1;
    localparam logic [2:0] ST_DUP      = 3'd2;
    localparam logic [2:0] ST_MISS     = 3'd3;
    localparam logic [2:0] ST_FULL     = 3'd4;

    typedef enum logic [1:0] {StIdle, StScan, StCommit, StResp} state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               hit_q;
    logic [IDX_W-1:0]   hit_idx_q;
    logic               free_found_q;
    logic [IDX_W-1:0]   free_idx_q;

    logic [1:0]         op_q;
    logic               op_ns_q;
    logic [SYM_W-1:0]   op_sym_q;
    logic [PKG_W-1:0]   op_pkg_q;

    logic               valid_q [DEPTH];
    logic               ns_q    [DEPTH];
    logic [SYM_W-1:0]   sym_q   [DEPTH];
    logic               local_q [DEPTH];
    logic [PKG_W-1:0]   pkg_q   [DEPTH];

    logic               cur_match;
    logic               cur_free;
    logic               hit_local;
    logic [PKG_W-1:0]   hit_pkg;
    logic [2:0]         status_d;
    logic               write_new;
    logic               retag;

    assign cur_match = valid_q[idx_q] && (ns_q[idx_q] == op_ns_q) && (sym_q[idx_q] == op_sym_q);
    assign cur_free  = !valid_q[idx_q];
    assign hit_local = local_q[hit_idx_q];
    assign hit_pkg   = pkg_q[hit_idx_q];

    // Resolution rule applied at COMMIT from the scan results.
    always_comb begin
        status_d  = ST_OK;
        write_new = 1'b0;
        retag     = 1'b0;
        case (op_q)
            OP_DECL: begin
                if (hit_q) begin
                    if (hit_local) begin
                        status_d = ST_DUP;
                    end else begin
                        status_d = ST_CONFLICT;
                        retag    = 1'b1;
                    end
                end else if (free_found_q) begin
                    write_new = 1'b1;
                end else begin
                    status_d = ST_FULL;
                end
            end
            OP_EXPORT: begin
                if (hit_q) begin
                    if (hit_local || (hit_pkg != op_pkg_q)) begin
                        status_d = ST_CONFLICT;
                    end
                end else if (free_found_q) begin
                    write_new = 1'b1;
                end else begin
                    status_d = ST_FULL;
                end
            end
            OP_LOOKUP: begin
                if (!hit_q) begin
                    status_d = ST_MISS;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            hit_q        <= 1'b0;
            hit_idx_q    <= '0;
            free_found_q <= 1'b0;
            free_idx_q   <= '0;
            op_q         <= OP_DECL;
            op_ns_q      <= 1'b0;
            op_sym_q     <= '0;
            op_pkg_q     <= '0;
            in_ready     <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_status   <= ST_OK;
            rsp_local    <= 1'b0;
            rsp_pkg      <= '0;
            occupancy    <= '0;
`ifdef SYMRES_STATS_EN
            conflict_cnt <= '0;
`endif
            for (int i = 0; i < int'(DEPTH); i++) begin
                valid_q[i] <= 1'b0;
                ns_q[i]    <= 1'b0;
                sym_q[i]   <= '0;
                local_q[i] <= 1'b0;
                pkg_q[i]   <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_q         <= in_op;
                        op_ns_q      <= in_ns;
                        op_sym_q     <= in_sym;
                        op_pkg_q     <= in_pkg;
                        idx_q        <= '0;
                        hit_q        <= 1'b0;
                        free_found_q <= 1'b0;
                        in_ready     <= 1'b0;
                        state_q      <= (in_op == OP_CLEAR) ? StCommit : StScan;
                    end
                end
                StScan: begin
                    if (cur_match) begin
                        hit_q     <= 1'b1;
                        hit_idx_q <= idx_q;
                    end
                    if (cur_free && !free_found_q) begin
                        free_found_q <= 1'b1;
                        free_idx_q   <= idx_q;
                    end
                    if (idx_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= StCommit;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                StCommit: begin
                    rsp_valid  <= 1'b1;
                    rsp_status <= status_d;
                    rsp_local  <= 1'b0;
                    rsp_pkg    <= '0;
                    if (op_q == OP_LOOKUP && hit_q) begin
                        rsp_local <= hit_local;
                        rsp_pkg   <= hit_pkg;
                    end
                    if (op_q == OP_CLEAR) begin
                        for (int i = 0; i < int'(DEPTH); i++) begin
                            valid_q[i] <= 1'b0;
                        end
                        occupancy <= '0;
                    end
                    if (write_new) begin
                        valid_q[free_idx_q] <= 1'b1;
                        ns_q[free_idx_q]    <= op_ns_q;
                        sym_q[free_idx_q]   <= op_sym_q;
                        local_q[free_idx_q] <= (op_q == OP_DECL);
                        pkg_q[free_idx_q]   <= (op_q == OP_DECL) ? '0 : op_pkg_q;
                        occupancy           <= occupancy + OCC_W'(1);
                    end
                    // A local declaration overrides an earlier import of the same name.
                    if (retag) begin
                        local_q[hit_idx_q] <= 1'b1;
                        pkg_q[hit_idx_q]   <= '0;
                    end
`ifdef SYMRES_STATS_EN
                    if (status_d == ST_CONFLICT && conflict_cnt != 16'hFFFF) begin
                        conflict_cnt <= conflict_cnt + 16'd1;
                    end
`endif
                    state_q <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_symbol_export_resolver.sv
// Randomized and directed checks of symbol_export_resolver (DEPTH=4) against a keyed-table model.
module tb_symbol_export_resolver;

    localparam int DEPTH = 4;
    localparam int SYM_W = 8;
    localparam int PKG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_op = '0;
    logic             in_ns = 1'b0;
    logic [SYM_W-1:0] in_sym = '0;
    logic [PKG_W-1:0] in_pkg = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [2:0]       rsp_status;
    logic             rsp_local;
    logic [PKG_W-1:0] rsp_pkg;
    logic [2:0]       occupancy;
`ifdef SYMRES_STATS_EN
    logic [15:0]      conflict_cnt;
    int               m_conf = 0;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: key = {ns, sym}; presence means a valid entry.
    bit               m_local [int];
    logic [PKG_W-1:0] m_pkg   [int];

    logic [2:0]       act_st, exp_st;
    logic             act_local, exp_local;
    logic [PKG_W-1:0] act_pkg, exp_pkg;
    int               act_lat;

    symbol_export_resolver #(.DEPTH(DEPTH), .SYM_W(SYM_W), .PKG_W(PKG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_ns      (in_ns),
        .in_sym     (in_sym),
        .in_pkg     (in_pkg),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_status (rsp_status),
        .rsp_local  (rsp_local),
        .rsp_pkg    (rsp_pkg),
`ifdef SYMRES_STATS_EN
        .conflict_cnt (conflict_cnt),
`endif
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    task automatic model_apply(input logic [1:0] op, input logic ns, input logic [SYM_W-1:0] sym,
                               input logic [PKG_W-1:0] pkg);
        int key = {23'd0, ns, sym};
        exp_st = 3'd0; exp_local = 1'b0; exp_pkg = '0;
        case (op)
            2'd0: begin
                if (m_local.exists(key)) begin
                    if (m_local[key]) exp_st = 3'd2;
                    else begin exp_st = 3'd1; m_local[key] = 1'b1; m_pkg[key] = '0; end
                end else if (m_local.num() < DEPTH) begin
                    m_local[key] = 1'b1; m_pkg[key] = '0;
                end else exp_st = 3'd4;
            end
            2'd1: begin
                if (m_local.exists(key)) begin
                    if (m_local[key] || m_pkg[key] != pkg) exp_st = 3'd1;
                end else if (m_local.num() < DEPTH) begin
                    m_local[key] = 1'b0; m_pkg[key] = pkg;
                end else exp_st = 3'd4;
            end
            2'd2: begin
                if (m_local.exists(key)) begin exp_local = m_local[key]; exp_pkg = m_pkg[key]; end
                else exp_st = 3'd3;
            end
            default: begin m_local.delete(); m_pkg.delete(); end
        endcase
`ifdef SYMRES_STATS_EN
        if (exp_st == 3'd1 && m_conf < 65535) m_conf++;
`endif
    endtask

    // Issue one op and collect its response; assumes we are #1 after a rising edge.
    task automatic exec(input logic [1:0] op, input logic ns, input logic [SYM_W-1:0] sym,
                        input logic [PKG_W-1:0] pkg);
        int n = 0;
        in_op = op; in_ns = ns; in_sym = sym; in_pkg = pkg; in_valid = 1'b1;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        act_lat = 1;
        while (!rsp_valid && act_lat < 100) begin @(posedge clk); #1; act_lat++; end
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL timeout op=%0d rsp_valid=0 required 1", op);
        end
        act_st = rsp_status; act_local = rsp_local; act_pkg = rsp_pkg;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        model_apply(op, ns, sym, pkg);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_status !== 3'd0 || rsp_local !== 1'b0
            || rsp_pkg !== '0 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL reset in_ready=%b rsp_valid=%b st=%0d local=%b pkg=%0d occ=%0d required 1 0 0 0 0 0",
                     in_ready, rsp_valid, rsp_status, rsp_local, rsp_pkg, occupancy);
        end
    endtask

    // Each row: op, ns, sym, pkg. Leading CLEAR isolates the scenario.
    task automatic test_dual_ns();
        int tbl [6][4] = '{'{3,0,0,0}, '{1,0,5,1}, '{1,1,5,1}, '{0,0,5,0}, '{0,1,5,0}, '{2,0,5,0}};
        for (int i = 0; i < 6; i++) begin
            exec(2'(tbl[i][0]), 1'(tbl[i][1]), 8'(tbl[i][2]), 4'(tbl[i][3]));
            checks++;
            if (act_st !== exp_st || act_local !== exp_local || act_pkg !== exp_pkg) begin
                errors++;
                $display("FAIL dual_ns[%0d] st/local/pkg=%0d/%b/%0d required %0d/%b/%0d",
                         i, act_st, act_local, act_pkg, exp_st, exp_local, exp_pkg);
            end
        end
        checks++;
        if (occupancy !== 3'd2) begin
            errors++; $display("FAIL dual_ns_occ occupancy=%0d required 2", occupancy);
        end
    endtask

    task automatic test_reverse();
        int tbl [5][4] = '{'{3,0,0,0}, '{0,0,7,0}, '{1,0,7,2}, '{2,0,7,0}, '{2,1,7,0}};
        for (int i = 0; i < 5; i++) begin
            exec(2'(tbl[i][0]), 1'(tbl[i][1]), 8'(tbl[i][2]), 4'(tbl[i][3]));
            checks++;
            if (act_st !== exp_st || act_local !== exp_local || act_pkg !== exp_pkg) begin
                errors++;
                $display("FAIL reverse[%0d] st/local/pkg=%0d/%b/%0d required %0d/%b/%0d",
                         i, act_st, act_local, act_pkg, exp_st, exp_local, exp_pkg);
            end
        end
    endtask

    task automatic test_duplicates();
        int tbl [7][4] = '{'{3,0,0,0}, '{1,1,3,2}, '{1,1,3,2}, '{1,1,3,4}, '{0,0,9,0}, '{0,0,9,0},
                           '{2,1,3,0}};
        for (int i = 0; i < 7; i++) begin
            exec(2'(tbl[i][0]), 1'(tbl[i][1]), 8'(tbl[i][2]), 4'(tbl[i][3]));
            checks++;
            if (act_st !== exp_st || act_local !== exp_local || act_pkg !== exp_pkg) begin
                errors++;
                $display("FAIL dup[%0d] st/local/pkg=%0d/%b/%0d required %0d/%b/%0d",
                         i, act_st, act_local, act_pkg, exp_st, exp_local, exp_pkg);
            end
        end
    endtask

    task automatic test_full();
        exec(2'd3, 1'b0, 8'd0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            exec(2'd0, 1'b0, 8'(10 + i), 4'd0);
            checks++;
            if (act_st !== (i < 4 ? 3'd0 : 3'd4)) begin
                errors++;
                $display("FAIL full_decl[%0d] status=%0d required %0d", i, act_st, (i < 4 ? 0 : 4));
            end
        end
        checks++;
        if (occupancy !== 3'd4) begin
            errors++; $display("FAIL full_occ occupancy=%0d required 4", occupancy);
        end
        exec(2'd3, 1'b0, 8'd0, 4'd0);
        checks++;
        if (act_st !== 3'd0 || occupancy !== 3'd0 || act_lat !== 2) begin
            errors++;
            $display("FAIL clear status=%0d occ=%0d lat=%0d required 0 0 2", act_st, occupancy, act_lat);
        end
    endtask

    task automatic test_timing();
        int lat;
        logic [2:0] st0;
        exec(2'd0, 1'b1, 8'd1, 4'd0);
        in_op = 2'd2; in_ns = 1'b1; in_sym = 8'd1; in_pkg = 4'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat !== DEPTH + 2) begin
            errors++; $display("FAIL latency cycles=%0d required %0d", lat, DEPTH + 2);
        end
        st0 = rsp_status;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_status !== 3'd0 || st0 !== 3'd0 || rsp_local !== 1'b1
                || rsp_pkg !== '0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d] valid=%b st=%0d local=%b pkg=%0d in_ready=%b required 1 0 1 0 0",
                         i, rsp_valid, rsp_status, rsp_local, rsp_pkg, in_ready);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        // Keep rsp_ready high in IDLE: must not produce anything.
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready rsp_valid=%b in_ready=%b required 0 1", rsp_valid, in_ready);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0] op;
        int r;
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 19);
            op = (r < 8) ? 2'd0 : (r < 14) ? 2'd1 : (r < 19) ? 2'd2 : 2'd3;
            exec(op, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 4)), 4'($urandom_range(0, 3)));
            checks++;
            if (act_st !== exp_st || act_local !== exp_local || act_pkg !== exp_pkg
                || int'(occupancy) !== m_local.num()) begin
                errors++;
                $display("FAIL random[%0d] op=%0d st/local/pkg/occ=%0d/%b/%0d/%0d required %0d/%b/%0d/%0d",
                         i, op, act_st, act_local, act_pkg, occupancy, exp_st, exp_local, exp_pkg,
                         m_local.num());
            end
        end
`ifdef SYMRES_STATS_EN
        checks++;
        if (int'(conflict_cnt) !== m_conf) begin
            errors++; $display("FAIL conflict_cnt got=%0d required %0d", conflict_cnt, m_conf);
        end
`endif
    endtask

    task automatic test_reset_mid_scan();
        exec(2'd0, 1'b0, 8'd20, 4'd0);
        in_op = 2'd2; in_ns = 1'b0; in_sym = 8'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        m_local.delete(); m_pkg.delete();
`ifdef SYMRES_STATS_EN
        m_conf = 0;
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset rsp_valid=%b in_ready=%b occ=%0d required 0 1 0",
                     rsp_valid, in_ready, occupancy);
        end
        exec(2'd2, 1'b0, 8'd20, 4'd0);
        checks++;
        if (act_st !== 3'd3 || act_local !== 1'b0 || act_pkg !== '0) begin
            errors++;
            $display("FAIL mid_reset_lookup st/local/pkg=%0d/%b/%0d required 3/0/0",
                     act_st, act_local, act_pkg);
        end
    endtask

    initial begin
        test_reset();
        test_dual_ns();
        test_reverse();
        test_duplicates();
        test_full();
        test_timing();
        test_random();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
